multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle control decoder: an FSM that sequences each instruction through fetch, decode, execute, memory and write-back over several cycles. It shares one memory port between instruction fetch and data access, with a req/ready handshake that tolerates any number of wait states. It adds a HALT opcode with resume and a retired-instruction counter. It sits between the instruction register/PC datapath and the shared memory.

---
 rtl/ctrl_pkg.sv | 10 +
 rtl/opcode_classifier.sv | 16 +
 rtl/multicycle_control_unit.sv | 72 +++++++
 tb/tb_multicycle_control_unit.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and opcode constants for the multi-cycle control unit.
package ctrl_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
   } state_t;
   typedef enum logic [1:0] {OP_ALU, OP_LOAD, OP_STORE, OP_HALT} op_class_t;
   // 3-bit base encodings; zero-extended to the configured opcode width at the point of use
   localparam logic [2:0] OPC_LOAD_3  = 3'b000;
   localparam logic [2:0] OPC_STORE_3 = 3'b100;
endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: maps a raw opcode onto its instruction class.
module opcode_classifier
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = 3
) (
   input  logic [OPCODE_W-1:0] opcode_i,
   output op_class_t           op_class_o
);
   localparam logic [OPCODE_W-1:0] OPC_LOAD  = OPCODE_W'(OPC_LOAD_3);
   localparam logic [OPCODE_W-1:0] OPC_STORE = OPCODE_W'(OPC_STORE_3);
   always_comb
      op_class_o = opcode_i == '1        ? OP_HALT  :
                   opcode_i == OPC_LOAD  ? OP_LOAD  :
                   opcode_i == OPC_STORE ? OP_STORE : OP_ALU;
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer sharing
// one memory port between fetch and data, with HALT/resume and a retire counter.
module multicycle_control_unit
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = 3,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   input  logic                resume,
   output logic                mem_req,
   output logic                mem_addr_src,
   output logic                mem_write_enable,
   output logic                ir_write,
   output logic                pc_write,
   output logic                reg_write_enable,
   output logic                result_src,
   output logic                halted,
   output logic [CNT_W-1:0]    retired
);
   state_t           state_q, state_d;
   op_class_t        op_q, op_d, op_class;
   logic [CNT_W-1:0] retired_q;
   logic             retire;
   opcode_classifier #(.OPCODE_W(OPCODE_W)) u_cls (
      .opcode_i  (opcode),
      .op_class_o(op_class)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= OP_ALU;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         retired_q <= retired_q + CNT_W'(retire);
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      state_d = S_FETCH;
         S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:    state_d = (op_class == OP_LOAD || op_class == OP_STORE) ? S_MEM :
                                op_class == OP_HALT ? S_HALT : S_EXECUTE;
         S_EXECUTE:   state_d = S_WRITEBACK;
         S_MEM:       state_d = !mem_ready ? S_MEM :
                                op_q == OP_STORE ? S_FETCH : S_WRITEBACK;
         S_WRITEBACK: state_d = S_FETCH;
         S_HALT:      state_d = resume ? S_FETCH : S_HALT;
         default:     state_d = S_IDLE;
      endcase
   end
   always_comb begin
      op_d             = state_q == S_DECODE ? op_class : op_q;
      mem_req          = state_q == S_FETCH || state_q == S_MEM;
      mem_addr_src     = state_q == S_MEM;
      mem_write_enable = state_q == S_MEM && op_q == OP_STORE;
      ir_write         = state_q == S_FETCH && mem_ready;
      pc_write         = state_q == S_FETCH && mem_ready;
      reg_write_enable = state_q == S_WRITEBACK;
      // only a LOAD routes data memory to the register file
      result_src       = !((state_q == S_WRITEBACK || state_q == S_MEM) && op_q == OP_LOAD);
      halted           = state_q == S_HALT;
      retire           = state_q == S_WRITEBACK || (mem_write_enable && mem_ready);
      retired          = retired_q;
   end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed per-cycle expectations pushed into a
// scoreboard queue; a negedge monitor pops and compares every output.
module tb_multicycle_control_unit;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] opcode;
   logic       mem_ready, resume;
   logic       mem_req, mem_addr_src, mem_write_enable, ir_write, pc_write;
   logic       reg_write_enable, result_src, halted;
   logic [3:0] retired;
   logic [3:0] ret = 4'd0;
   logic [11:0] sb[$];
   int errors = 0;
   int checks = 0;
   int cycle_no = 0;

   multicycle_control_unit #(.OPCODE_W(3), .CNT_W(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .opcode          (opcode),
      .mem_ready       (mem_ready),
      .resume          (resume),
      .mem_req         (mem_req),
      .mem_addr_src    (mem_addr_src),
      .mem_write_enable(mem_write_enable),
      .ir_write        (ir_write),
      .pc_write        (pc_write),
      .reg_write_enable(reg_write_enable),
      .result_src      (result_src),
      .halted          (halted),
      .retired         (retired)
   );

   always #5 clk = ~clk;

   // expected vector: {req, addr_src, mwe, irw, pcw, rwe, rsrc, halted, retired}
   function automatic logic [11:0] E(input logic rq, input logic sr, input logic mw, input logic iw,
                                     input logic pw, input logic rw, input logic rs, input logic h);
      return {rq, sr, mw, iw, pw, rw, rs, h, ret};
   endfunction

   always @(negedge clk) begin
      logic [11:0] got, exp;
      cycle_no++;
      if (sb.size() != 0) begin
         exp = sb.pop_front();
         got = {mem_req, mem_addr_src, mem_write_enable, ir_write, pc_write,
                reg_write_enable, result_src, halted, retired};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL outs@cycle%0d got=%b required=%b (req,src,mwe,irw,pcw,rwe,rsrc,halt,ret)",
                     cycle_no, got, exp);
         end
      end
   end

   task automatic cyc(input logic [2:0] op, input logic rdy, input logic res, input logic [11:0] e);
      opcode = op; mem_ready = rdy; resume = res;
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic fetch_dec(input logic [2:0] op, input int fw, input logic dres);
      for (int i = 0; i < fw; i++) cyc(op, 1'b0, 1'b0, E(1,0,0,0,0,0,1,0));
      cyc(op, 1'b1, 1'b0, E(1,0,0,1,1,0,1,0));
      cyc(op, 1'b1, dres, E(0,0,0,0,0,0,1,0));
   endtask

   task automatic alu(input logic [2:0] op, input int fw);
      fetch_dec(op, fw, 1'b1);
      cyc(op, 1'b1, 1'b1, E(0,0,0,0,0,0,1,0));
      cyc(op, 1'b1, 1'b0, E(0,0,0,0,0,1,1,0));
      ret++;
   endtask

   task automatic load(input int mw);
      fetch_dec(3'b000, 0, 1'b0);
      for (int i = 0; i < mw; i++) cyc(3'b000, 1'b0, 1'b0, E(1,1,0,0,0,0,0,0));
      cyc(3'b000, 1'b1, 1'b0, E(1,1,0,0,0,0,0,0));
      cyc(3'b000, 1'b1, 1'b0, E(0,0,0,0,0,1,0,0));
      ret++;
   endtask

   task automatic store(input int mw);
      fetch_dec(3'b100, 0, 1'b0);
      for (int i = 0; i < mw; i++) cyc(3'b100, 1'b0, 1'b0, E(1,1,1,0,0,0,1,0));
      cyc(3'b100, 1'b1, 1'b0, E(1,1,1,0,0,0,1,0));
      ret++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; opcode = 3'b001; mem_ready = 1'b1; resume = 1'b0;
      sb.push_back(E(0,0,0,0,0,0,1,0));
      @(negedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(3'b001, 1'b1, 1'b0, E(0,0,0,0,0,0,1,0));
      alu(3'b001, 0);
      load(3);
      store(0);
      store(2);
      alu(3'b010, 1);
      load(0);
      // HALT: resume during DECODE must be ignored, then dwell 10 cycles
      fetch_dec(3'b111, 0, 1'b1);
      for (int i = 0; i < 10; i++) cyc(3'b111, 1'b1, 1'b0, E(0,0,0,0,0,0,1,1));
      cyc(3'b111, 1'b0, 1'b1, E(0,0,0,0,0,0,1,1));
      alu(3'b011, 0);
      alu(3'b101, 0);
      alu(3'b110, 0);
      for (int i = 0; i < 16; i++) alu((i % 2 == 0) ? 3'b011 : 3'b110, 0);
      // reset asserted mid-MEM of a STORE
      fetch_dec(3'b100, 0, 1'b0);
      cyc(3'b100, 1'b0, 1'b0, E(1,1,1,0,0,0,1,0));
      rst_n = 1'b0;
      ret = 4'd0;
      sb.push_back(E(0,0,0,0,0,0,1,0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(3'b001, 1'b1, 1'b0, E(0,0,0,0,0,0,1,0));
      alu(3'b001, 0);
      @(negedge clk); #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
